// File: rtl/prog_store.sv
// Program store: nibble loader writes bytes from address 0, CPU fetches instruction bytes from it.
// Latency: read is combinational; a byte lands on the edge its low nibble transfers; CPU released 1 cycle after DONE.
// Backpressure: ld_ready only in HI/LO (and CHK with PROG_STORE_CHECKSUM_EN); at most one nibble per cycle.
module prog_store #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] eeprom_data,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [3:0]        ld_data,
    input  logic              ld_end,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_err,
    output logic [ADDR_W:0]   wr_count,
`ifdef PROG_STORE_CHECKSUM_EN
    output logic [7:0]        chk_sum,
`endif
    output logic              cpu_rst_n
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        DONE = 3'd3
`ifdef PROG_STORE_CHECKSUM_EN
        ,CHK = 3'd4
`endif
    } state_t;

`ifdef PROG_STORE_CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state, state_nx;
    logic [3:0]        hi_reg;
    logic [ADDR_W-1:0] wr_ptr;
    logic              cpu_rst_q;
    logic              start_load, take_hi, do_wr, set_err;
    logic [DATA_W-1:0] wr_byte;
    logic [DATA_W-1:0] mem [DEPTH];
`ifdef PROG_STORE_CHECKSUM_EN
    logic              chk_phase;
`endif

    assign wr_byte = DATA_W'({hi_reg, ld_data});

    always_comb begin
        state_nx   = state;
        start_load = 1'b0;
        take_hi    = 1'b0;
        do_wr      = 1'b0;
        set_err    = 1'b0;
        if (ld_start) begin
            // restart wins over any transfer or termination in the same cycle
            start_load = 1'b1;
            state_nx   = HI;
        end else begin
            case (state)
                HI: begin
                    if (ld_valid) begin
                        take_hi  = 1'b1;
                        state_nx = LO;
                    end
                    if (ld_end) state_nx = END_ST;
                end
                LO: begin
                    if (ld_valid) begin
                        do_wr = 1'b1;
                        if (ld_end || wr_ptr == ADDR_W'(DEPTH - 1)) state_nx = END_ST;
                        else                                        state_nx = HI;
                    end else if (ld_end) begin
                        set_err  = 1'b1;
                        state_nx = END_ST;
                    end
                end
`ifdef PROG_STORE_CHECKSUM_EN
                CHK: begin
                    if (ld_valid) begin
                        if (!chk_phase) begin
                            take_hi = 1'b1;
                        end else begin
                            set_err  = (wr_byte != chk_sum);
                            state_nx = DONE;
                        end
                    end
                end
`endif
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hi_reg    <= '0;
            wr_ptr    <= '0;
            wr_count  <= '0;
            ld_err    <= 1'b0;
            cpu_rst_q <= 1'b0;
`ifdef PROG_STORE_CHECKSUM_EN
            chk_sum   <= '0;
            chk_phase <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cpu_rst_q <= (state == DONE);
            if (take_hi) hi_reg <= ld_data;
            if (start_load) begin
                wr_ptr   <= '0;
                wr_count <= '0;
                ld_err   <= 1'b0;
`ifdef PROG_STORE_CHECKSUM_EN
                chk_sum   <= '0;
                chk_phase <= 1'b0;
`endif
            end else begin
                if (do_wr) begin
                    wr_ptr   <= wr_ptr + ADDR_W'(1);
                    wr_count <= wr_count + (ADDR_W + 1)'(1);
`ifdef PROG_STORE_CHECKSUM_EN
                    chk_sum  <= chk_sum + wr_byte;
`endif
                end
                if (set_err) ld_err <= 1'b1;
`ifdef PROG_STORE_CHECKSUM_EN
                if (take_hi && state == CHK) chk_phase <= 1'b1;
`endif
            end
        end
    end

    // program memory survives reset
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_byte;
    end

    // held low in every state but DONE, released one cycle after DONE is entered
    assign cpu_rst_n   = cpu_rst_q && (state == DONE);
    assign eeprom_data = cpu_rst_n ? mem[address] : '0;
`ifdef PROG_STORE_CHECKSUM_EN
    assign ld_ready    = (state == HI) || (state == LO) || (state == CHK);
    assign ld_busy     = (state == HI) || (state == LO) || (state == CHK);
`else
    assign ld_ready    = (state == HI) || (state == LO);
    assign ld_busy     = (state == HI) || (state == LO);
`endif

endmodule

// File: tb/tb_prog_store.sv
// Directed bench for prog_store: inputs driven and outputs sampled on the falling edge.
module tb_prog_store;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] eeprom_data;
    logic       ld_start = 1'b0, ld_valid = 1'b0, ld_end = 1'b0;
    logic [3:0] ld_data = '0;
    logic       ld_ready, ld_busy, ld_err, cpu_rst_n;
    logic [8:0] wr_count;
`ifdef PROG_STORE_CHECKSUM_EN
    logic [7:0] chk_sum;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_store dut (
        .clk(clk), .rst(rst), .address(address), .eeprom_data(eeprom_data),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_end(ld_end),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_err(ld_err), .wr_count(wr_count),
`ifdef PROG_STORE_CHECKSUM_EN
        .chk_sum(chk_sum),
`endif
        .cpu_rst_n(cpu_rst_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nib(input logic [3:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        step();
        ld_valid = 1'b0;
    endtask

    task automatic start();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic end_pulse();
        ld_end = 1'b1;
        step();
        ld_end = 1'b0;
    endtask

    task automatic read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        address = a;
        #1;
        chk(tag, eeprom_data, exp);
    endtask

    initial begin
        // reset
        step();
        step();
        chk("rst_ready", ld_ready, 0);
        chk("rst_busy", ld_busy, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_count", wr_count, 0);
        chk("rst_cpu", cpu_rst_n, 0);
        read("rst_data", 8'h00, 8'h00);
        rst = 1'b1;
        step();
        nib(4'h7);
        chk("idle_valid_ignored", wr_count, 0);
        chk("idle_ready", ld_ready, 0);

        // basic load 12, AB
        start();
        chk("hi_ready", ld_ready, 1);
        chk("hi_busy", ld_busy, 1);
        chk("hi_cpu", cpu_rst_n, 0);
        nib(4'h1);
        nib(4'h2);
        read("load_data_held", 8'h00, 8'h00);
        nib(4'hA);
        chk("lo_cpu", cpu_rst_n, 0);
        nib(4'hB);
        chk("load_count", wr_count, 2);
        end_pulse();
`ifdef PROG_STORE_CHECKSUM_EN
        chk("chk_state_ready", ld_ready, 1);
        chk("chk_sum_val", chk_sum, 8'hBD);
        nib(4'hB);
        nib(4'hD);
`endif
        chk("done_ready", ld_ready, 0);
        chk("done_busy", ld_busy, 0);
        chk("done_cpu_still_held", cpu_rst_n, 0);
        chk("done_err", ld_err, 0);
        step();
        chk("done_cpu_released", cpu_rst_n, 1);
        read("read_addr1", 8'h01, 8'hAB);
        read("read_addr0", 8'h00, 8'h12);

        // partial byte then ld_end
        start();
        chk("restart_cpu_drop", cpu_rst_n, 0);
        nib(4'h5);
        end_pulse();
        chk("partial_err", ld_err, 1);
        chk("partial_count", wr_count, 0);
`ifdef PROG_STORE_CHECKSUM_EN
        nib(4'h0);
        nib(4'h0);
        chk("partial_err_kept", ld_err, 1);
`endif
        step();
        read("partial_mem0_kept", 8'h00, 8'h12);

        // restart mid-load together with ld_valid
        start();
        chk("start_clears_err", ld_err, 0);
        nib(4'h3);
        nib(4'h4);
        nib(4'h7);
        ld_start = 1'b1;
        nib(4'h9);
        ld_start = 1'b0;
        chk("restart_count", wr_count, 0);
        chk("restart_ready", ld_ready, 1);
        chk("restart_err", ld_err, 0);
        nib(4'h5);
        nib(4'h6);
        chk("restart_hi_state", wr_count, 1);

        // full 256-byte stream: byte k = k
        start();
        for (int k = 0; k < 256; k++) begin
            nib(4'(k >> 4));
            if (k == 255) chk("stream_ready_before_last", ld_ready, 1);
            nib(4'(k));
        end
        chk("stream_count", wr_count, 256);
`ifdef PROG_STORE_CHECKSUM_EN
        chk("stream_enters_chk", ld_ready, 1);
        nib(4'h8);
        nib(4'h0);
        chk("stream_sum_ok", ld_err, 0);
`endif
        chk("stream_ready_done", ld_ready, 0);
        chk("stream_busy_done", ld_busy, 0);
        nib(4'hF);
        chk("stream_extra_rejected", wr_count, 256);
        step();
        chk("stream_cpu", cpu_rst_n, 1);
        read("stream_5a", 8'h5A, 8'h5A);
        read("stream_ff", 8'hFF, 8'hFF);
        read("stream_01", 8'h01, 8'h01);

`ifdef PROG_STORE_CHECKSUM_EN
        // checksum mismatch
        start();
        nib(4'h1);
        nib(4'h2);
        nib(4'hA);
        nib(4'hB);
        end_pulse();
        nib(4'hB);
        nib(4'hC);
        chk("chk_mismatch_err", ld_err, 1);
        chk("chk_mismatch_done", ld_ready, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
